// File: rtl/data_cache.sv
// Direct-mapped write-through no-write-allocate data cache; load hits answer combinationally in the request cycle.
// Misses and stores hold Stall high through one outstanding mem_req/mem_ready handshake, then release for a single DONE cycle.
module data_cache #(
  parameter int SETS   = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] A,
  input  logic              DE,
  input  logic              WE,
  input  logic [31:0]       WD,
  input  logic [1:0]        ByteSelect,
  input  logic              SignExtend,
  output logic [31:0]       RD,
  output logic              Stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX - 2;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t           state;
  logic [SETS-1:0]  validBits;
  logic [TAG_W-1:0] tagArr  [SETS];
  logic [31:0]      dataArr [SETS];

  logic [IDX-1:0]   index;
  logic [TAG_W-1:0] reqTag;
  logic [31:0]      lineWord;
  logic             hit;

  assign index    = A[IDX+1:2];
  assign reqTag   = A[ADDR_W-1:IDX+2];
  assign lineWord = dataArr[index];
  assign hit      = DE & validBits[index] & (tagArr[index] == reqTag);

  // Fill and merge target the captured request, not whatever A shows now.
  logic [IDX-1:0]   fillIdx;
  logic [TAG_W-1:0] fillTag;
  logic             writeHit;
  logic [31:0]      mergedWord;

  assign fillIdx  = mem_addr[IDX+1:2];
  assign fillTag  = mem_addr[ADDR_W-1:IDX+2];
  assign writeHit = validBits[fillIdx] & (tagArr[fillIdx] == fillTag);

  always_comb begin
    mergedWord = dataArr[fillIdx];
    for (int b = 0; b < 4; b++) begin
      if (mem_wstrb[b]) mergedWord[8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  logic [31:0] storeData;
  logic [3:0]  storeStrb;

  always_comb begin
    case (ByteSelect)
      2'b00: begin
        storeData = {4{WD[7:0]}};
        storeStrb = 4'b0001 << A[1:0];
      end
      2'b01: begin
        storeData = {2{WD[15:0]}};
        storeStrb = A[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        storeData = WD;
        storeStrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    Stall = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:        Stall = DE & (WE | ~hit);
        FILL, WRITE: Stall = 1'b1;
        default:     Stall = 1'b0;
      endcase
    end
  end

  logic [7:0]  byteVal;
  logic [15:0] halfVal;
  logic [31:0] rdVal;

  always_comb begin
    case (A[1:0])
      2'b00:   byteVal = lineWord[7:0];
      2'b01:   byteVal = lineWord[15:8];
      2'b10:   byteVal = lineWord[23:16];
      default: byteVal = lineWord[31:24];
    endcase
    halfVal = A[1] ? lineWord[31:16] : lineWord[15:0];
    case (ByteSelect)
      2'b00:   rdVal = {{24{SignExtend & byteVal[7]}}, byteVal};
      2'b01:   rdVal = {{16{SignExtend & halfVal[15]}}, halfVal};
      default: rdVal = lineWord;
    endcase
    RD = (!rst && DE && !Stall) ? rdVal : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      validBits <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (DE && (WE || !hit)) begin
            state     <= WE ? WRITE : FILL;
            mem_req   <= 1'b1;
            mem_we    <= WE;
            mem_addr  <= {A[ADDR_W-1:2], 2'b00};
            mem_wdata <= storeData;
            mem_wstrb <= WE ? storeStrb : 4'b0000;
          end
        end
        FILL: begin
          if (mem_ready) begin
            validBits[fillIdx] <= 1'b1;
            mem_req            <= 1'b0;
            state              <= DONE;
          end
        end
        WRITE: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data need no reset: validBits alone decides whether a line is live.
  always_ff @(posedge clk) begin
    if (!rst && mem_ready) begin
      if (state == FILL) begin
        tagArr[fillIdx]  <= fillTag;
        dataArr[fillIdx] <= mem_rdata;
      end else if (state == WRITE && writeHit) begin
        dataArr[fillIdx] <= mergedWord;
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: stimulus queues expected outcomes, a negedge monitor checks each completed access.
module tb_data_cache;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic        DE;
  logic        WE;
  logic [31:0] WD;
  logic [1:0]  ByteSelect;
  logic        SignExtend;
  logic [31:0] RD;
  logic        Stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  data_cache #(.SETS(64), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .A(A), .DE(DE), .WE(WE), .WD(WD),
    .ByteSelect(ByteSelect), .SignExtend(SignExtend), .RD(RD), .Stall(Stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          chkRd;
    logic [31:0] rd;
    int          stalls;
    bit          req;
    bit          we;
    logic [31:0] addr;
    bit          chkW;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } exp_t;

  exp_t sb[$];
  int   testCount = 0;
  int   failCount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    testCount++;
    if (act !== expv) begin
      failCount++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic push(input bit chkRd, input logic [31:0] rd, input int stalls, input bit req,
                      input bit we, input logic [31:0] addr, input bit chkW,
                      input logic [31:0] wdata, input logic [3:0] wstrb);
    exp_t e;
    e.chkRd = chkRd; e.rd = rd; e.stalls = stalls; e.req = req; e.we = we;
    e.addr = addr; e.chkW = chkW; e.wdata = wdata; e.wstrb = wstrb;
    sb.push_back(e);
  endtask

  // Monitor: counts stall cycles, captures the first mem_req beat, scores each completed access.
  int          stallCnt = 0;
  bit          reqSeen  = 0;
  logic        capWe;
  logic [31:0] capAddr;
  logic [31:0] capWdata;
  logic [3:0]  capWstrb;

  always @(negedge clk) begin
    if (rst) begin
      stallCnt = 0;
      reqSeen  = 0;
    end else begin
      if (mem_req && !reqSeen) begin
        reqSeen  = 1;
        capWe    = mem_we;
        capAddr  = mem_addr;
        capWdata = mem_wdata;
        capWstrb = mem_wstrb;
      end
      if (DE && Stall) begin
        stallCnt++;
        check("rd_zero_while_stalled", RD, 32'h0);
      end else if (DE && !Stall) begin
        if (sb.size() == 0) begin
          check("unexpected_completion", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("stall_cycles", stallCnt, e.stalls);
          check("mem_req_issued", {31'b0, reqSeen}, {31'b0, e.req});
          if (e.req) begin
            check("mem_we", {31'b0, capWe}, {31'b0, e.we});
            check("mem_addr", capAddr, e.addr);
            if (e.chkW) begin
              check("mem_wdata", capWdata, e.wdata);
              check("mem_wstrb", {28'b0, capWstrb}, {28'b0, e.wstrb});
            end
          end
          if (e.chkRd) check("rd", RD, e.rd);
        end
        stallCnt = 0;
        reqSeen  = 0;
      end
    end
  end

  // Presents one request and plays backing memory: mem_ready on the lat-th cycle of mem_req.
  task automatic access(input logic [31:0] addr, input bit we, input logic [31:0] wd,
                        input logic [1:0] bsel, input bit sext, input int lat,
                        input logic [31:0] rdata);
    int  reqCycles = 0;
    bit  done = 0;
    A = addr; DE = 1'b1; WE = we; WD = wd; ByteSelect = bsel; SignExtend = sext;
    mem_rdata = rdata;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      done = DE && !Stall;
      @(posedge clk);
      #1;
      if (mem_req) begin
        reqCycles++;
        mem_ready = (reqCycles == lat);
      end else begin
        mem_ready = 1'b0;
      end
    end
    if (!done) check("access_timeout", 32'h1, 32'h0);
  endtask

  initial begin
    rst = 1'b1; A = '0; DE = 1'b0; WE = 1'b0; WD = '0; ByteSelect = 2'b10;
    SignExtend = 1'b0; mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall", {31'b0, Stall}, 32'h0);
    check("reset_rd", RD, 32'h0);
    check("reset_mem_req", {31'b0, mem_req}, 32'h0);
    check("reset_mem_we", {31'b0, mem_we}, 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_mem_wdata", mem_wdata, 32'h0);
    check("reset_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Cold miss, hits, sub-word lanes.
    push(1, 32'hDEADBEEF, 4, 1, 0, 32'h100, 0, 0, 0);
    access(32'h100, 0, 0, 2'b10, 0, 3, 32'hDEADBEEF);
    push(1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    access(32'h100, 0, 0, 2'b10, 0, 0, 0);
    push(1, 32'hFFFFFFDE, 0, 0, 0, 0, 0, 0, 0);
    access(32'h103, 0, 0, 2'b00, 1, 0, 0);
    push(1, 32'h0000DEAD, 0, 0, 0, 0, 0, 0, 0);
    access(32'h102, 0, 0, 2'b01, 0, 0, 0);

    // Store byte to a cached line merges into the line.
    push(0, 0, 2, 1, 1, 32'h100, 1, 32'hABABABAB, 4'b0010);
    access(32'h101, 1, 32'h000000AB, 2'b00, 0, 1, 0);
    push(1, 32'hDEADABEF, 0, 0, 0, 0, 0, 0, 0);
    access(32'h100, 0, 0, 2'b10, 0, 0, 0);

    // Store word to an uncached address: no allocate, cached 0x100 untouched.
    push(0, 0, 3, 1, 1, 32'h200, 1, 32'h12345678, 4'b1111);
    access(32'h200, 1, 32'h12345678, 2'b10, 0, 2, 0);
    push(1, 32'hDEADABEF, 0, 0, 0, 0, 0, 0, 0);
    access(32'h100, 0, 0, 2'b10, 0, 0, 0);
    push(1, 32'h0BADF00D, 2, 1, 0, 32'h200, 0, 0, 0);
    access(32'h200, 0, 0, 2'b10, 0, 1, 32'h0BADF00D);

    // 0x100 and 0x200 share index 0: each load evicts the other.
    push(1, 32'h11112222, 2, 1, 0, 32'h100, 0, 0, 0);
    access(32'h100, 0, 0, 2'b10, 0, 1, 32'h11112222);
    push(1, 32'h33334444, 3, 1, 0, 32'h200, 0, 0, 0);
    access(32'h200, 0, 0, 2'b10, 0, 2, 32'h33334444);
    push(1, 32'h11112222, 2, 1, 0, 32'h100, 0, 0, 0);
    access(32'h100, 0, 0, 2'b10, 0, 1, 32'h11112222);

    // Upper half store, then signed/unsigned sub-word reads of the merged word.
    push(0, 0, 2, 1, 1, 32'h100, 1, 32'h80018001, 4'b1100);
    access(32'h102, 1, 32'h00008001, 2'b01, 0, 1, 0);
    push(1, 32'hFFFF8001, 0, 0, 0, 0, 0, 0, 0);
    access(32'h102, 0, 0, 2'b01, 1, 0, 0);
    push(1, 32'h00000080, 0, 0, 0, 0, 0, 0, 0);
    access(32'h103, 0, 0, 2'b00, 0, 0, 0);
    push(1, 32'h00000022, 0, 0, 0, 0, 0, 0, 0);
    access(32'h100, 0, 0, 2'b00, 1, 0, 0);
    push(1, 32'h80012222, 0, 0, 0, 0, 0, 0, 0);
    access(32'h100, 0, 0, 2'b11, 0, 0, 0);

    // Reset in the middle of a fill, then a late mem_ready.
    A = 32'h300; DE = 1'b1; WE = 1'b0; ByteSelect = 2'b10; SignExtend = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("fill_mem_req_up", {31'b0, mem_req}, 32'h1);
    rst = 1'b1; DE = 1'b0;
    @(posedge clk);
    #1;
    check("rst_drops_mem_req", {31'b0, mem_req}, 32'h0);
    check("rst_stall_low", {31'b0, Stall}, 32'h0);
    rst = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    check("late_ready_no_req", {31'b0, mem_req}, 32'h0);
    check("late_ready_no_stall", {31'b0, Stall}, 32'h0);
    push(1, 32'h55556666, 2, 1, 0, 32'h100, 0, 0, 0);
    access(32'h100, 0, 0, 2'b10, 0, 1, 32'h55556666);

    DE = 1'b0;
    @(negedge clk);
    check("idle_rd_zero", RD, 32'h0);
    check("idle_stall_low", {31'b0, Stall}, 32'h0);
    check("scoreboard_drained", sb.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
